// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage skid buffer.
package pipe_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 8;

  // Control payload bit positions
  localparam int CTRL_BRANCH   = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_JUMP     = 5;
  localparam int CTRL_ZERO     = 6;
  localparam int CTRL_SPARE    = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer entry: loadable payload register with a valid bit.
// Loading sets valid; clearing drops valid but keeps the payload.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);

  logic [W-1:0] data_q;
  logic         vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (ld_i) begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with optional 2-entry skid buffer (registered in_ready)
// or a single register with combinational ready.
//   state | meaning
//   EMPTY | no entry held
//   ONE   | main entry valid
//   FULL  | main and skid entries valid, input blocked
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  localparam int ENT_W = DATA_W + CTRL_W;

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic [15:0]       stall_q, stall_d;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic              main_vld, skid_vld;
  logic [ENT_W-1:0]  main_q, skid_q, main_d, in_ent;
  logic              in_hs, out_hs;

  assign in_ent = {in_ctrl, in_data};
  assign in_hs  = in_valid & in_ready;
  assign out_hs = main_vld & out_ready;

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_d   = in_ent;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_hs) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_ld = 1'b1;
          end else if (in_hs) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (out_hs) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            main_ld  = 1'b1;
            main_d   = skid_q;
            skid_clr = 1'b1;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_vld && !out_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      stall_q    <= stall_d;
    end
  end

  pipe_entry_reg #(.W(ENT_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .ld_i  (main_ld),
    .clr_i (main_clr),
    .d_i   (main_d),
    .q_o   (main_q),
    .vld_o (main_vld)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .ld_i  (skid_ld),
        .clr_i (skid_clr),
        .d_i   (in_ent),
        .q_o   (skid_q),
        .vld_o (skid_vld)
      );
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_q   = '0;
      assign skid_vld = 1'b0;
      assign in_ready = ~main_vld | out_ready;
    end
  endgenerate

  assign out_valid = main_vld;
  assign out_data  = main_q[DATA_W-1:0];
  // Bubbles carry no control so they cannot write registers or memory
  assign out_ctrl  = main_vld ? main_q[ENT_W-1:DATA_W] : '0;
  assign occupancy = {skid_vld, main_vld & ~skid_vld};
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: SKID=1 instance for the main sequences,
// SKID=0 instance for the combinational-ready variant.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        rst, fl, iv, irdy, ov, ordy;
  logic [95:0] id, od;
  logic [7:0]  ic, oc;
  logic [1:0]  occ;
  logic [15:0] sc;

  // SKID=0 instance
  logic        rst0, fl0, iv0, irdy0, ov0, ordy0;
  logic [95:0] id0, od0;
  logic [7:0]  ic0, oc0;
  logic [1:0]  occ0;
  logic [15:0] sc0;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_stage_skid #(.DATA_W(96), .CTRL_W(8), .SKID(1)) u_dut (
    .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(irdy),
    .in_data(id), .in_ctrl(ic), .out_valid(ov), .out_ready(ordy),
    .out_data(od), .out_ctrl(oc), .occupancy(occ), .stall_cnt(sc)
  );

  pipe_stage_skid #(.DATA_W(96), .CTRL_W(8), .SKID(0)) u_dut0 (
    .clk(clk), .reset(rst0), .flush(fl0), .in_valid(iv0), .in_ready(irdy0),
    .in_data(id0), .in_ctrl(ic0), .out_valid(ov0), .out_ready(ordy0),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0), .stall_cnt(sc0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        mv;
    logic [95:0] md;
    logic        hs;

    rst = 1'b1; fl = 1'b0; iv = 1'b0; id = '0; ic = '0; ordy = 1'b1;
    rst0 = 1'b1; fl0 = 1'b0; iv0 = 1'b0; id0 = '0; ic0 = '0; ordy0 = 1'b0;
    step();
    step();
    chk("rst_ov", ov, 1'b0);
    chk("rst_od", od, 96'h0);
    chk("rst_oc", oc, 8'h0);
    chk("rst_occ", occ, 2'd0);
    chk("rst_sc", sc, 16'd0);
    chk("rst_irdy", irdy, 1'b1);
    rst = 1'b0; rst0 = 1'b0;

    // single entry, 1-cycle latency
    iv = 1'b1; id = 96'h1; ic = 8'h10; ordy = 1'b1;
    step();
    iv = 1'b0;
    chk("t1_ov", ov, 1'b1);
    chk("t1_od", od, 96'h1);
    chk("t1_oc", oc, 8'h10);
    step();
    chk("t1_ov_after", ov, 1'b0);
    chk("t1_oc_bubble", oc, 8'h0);
    chk("t1_od_hold", od, 96'h1);
    chk("t1_occ", occ, 2'd0);

    // back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      iv = 1'b1; id = 96'(i); ic = 8'(i);
      step();
      chk("t2_ov", ov, 1'b1);
      chk("t2_od", od, 96'(i));
      chk("t2_occ", occ, 2'd1);
    end
    iv = 1'b0;
    step();
    chk("t2_drain", ov, 1'b0);
    chk("t2_sc", sc, 16'd0);

    // fill skid with A,B; C refused; drain in order
    ordy = 1'b0; iv = 1'b1; id = 96'hA; ic = 8'h0A;
    step();
    chk("t3_irdy_one", irdy, 1'b1);
    id = 96'hB; ic = 8'h0B;
    step();
    id = 96'hC; ic = 8'h0C;
    step();
    chk("t3_occ_full", occ, 2'd2);
    chk("t3_irdy_full", irdy, 1'b0);
    chk("t3_headA", od, 96'hA);
    ordy = 1'b1;
    step();
    chk("t3_headB", od, 96'hB);
    chk("t3_occ_one", occ, 2'd1);
    chk("t3_irdy_back", irdy, 1'b1);
    step();
    chk("t3_headC", od, 96'hC);
    chk("t3_ocC", oc, 8'h0C);
    iv = 1'b0;
    step();
    chk("t3_empty", ov, 1'b0);
    chk("t3_sc", sc, 16'd2);

    // flush from FULL with D offered
    ordy = 1'b0; iv = 1'b1; id = 96'h11; ic = 8'h11;
    step();
    id = 96'h12; ic = 8'h12;
    step();
    chk("t4_full", occ, 2'd2);
    fl = 1'b1; id = 96'hDD; ic = 8'hDD;
    step();
    fl = 1'b0; iv = 1'b0;
    chk("t4_occ", occ, 2'd0);
    chk("t4_ov", ov, 1'b0);
    chk("t4_oc", oc, 8'h0);
    chk("t4_irdy", irdy, 1'b1);
    ordy = 1'b1;
    step();
    chk("t4_noD_1", ov, 1'b0);
    step();
    chk("t4_noD_2", ov, 1'b0);
    chk("t4_sc", sc, 16'd4);

    // flush from ONE discards an accepted handshake
    ordy = 1'b0; iv = 1'b1; id = 96'h33; ic = 8'h33;
    step();
    fl = 1'b1; id = 96'hEE; ic = 8'hEE;
    chk("t4b_irdy_flush", irdy, 1'b1);
    step();
    fl = 1'b0; iv = 1'b0;
    chk("t4b_ov", ov, 1'b0);
    chk("t4b_occ", occ, 2'd0);
    ordy = 1'b1;
    step();
    chk("t4b_noE", ov, 1'b0);
    chk("t4b_sc", sc, 16'd5);

    // reset together with flush, mid-operation
    ordy = 1'b0; iv = 1'b1; id = 96'h44; ic = 8'h44;
    step();
    id = 96'h45; ic = 8'h45;
    step();
    rst = 1'b1; fl = 1'b1; iv = 1'b0;
    step();
    chk("t5_occ", occ, 2'd0);
    chk("t5_ov", ov, 1'b0);
    chk("t5_od", od, 96'h0);
    chk("t5_sc", sc, 16'd0);
    chk("t5_irdy", irdy, 1'b1);
    rst = 1'b0; fl = 1'b0; ordy = 1'b1;
    step();
    chk("t5_noout", ov, 1'b0);

    // SKID=0: out_ready toggling, in_valid held
    mv = 1'b0; md = '0;
    iv0 = 1'b1; id0 = 96'h100; ic0 = 8'h5A;
    for (int i = 0; i < 12; i++) begin
      ordy0 = i[0];
      #1;
      chk("s0_irdy", irdy0, !mv || ordy0);
      chk("s0_ov", ov0, mv);
      if (mv) chk("s0_od", od0, md);
      hs = !mv || ordy0;
      step();
      if (hs) begin
        mv = 1'b1;
        md = id0;
        id0 = id0 + 96'h1;
      end else if (mv && ordy0) begin
        mv = 1'b0;
      end
      chk("s0_occ", occ0, {1'b0, mv});
    end
    iv0 = 1'b0;

    // stall counter saturation
    ordy = 1'b0; iv = 1'b1; id = 96'h55; ic = 8'h55;
    step();
    iv = 1'b0;
    repeat (65534) step();
    chk("t6_sc_fffe", sc, 16'hFFFE);
    step();
    chk("t6_sc_ffff", sc, 16'hFFFF);
    repeat (4466) step();
    chk("t6_sc_sat", sc, 16'hFFFF);
    chk("t6_ov", ov, 1'b1);
    chk("t6_od", od, 96'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 96, SHALL set the width of the datapath payload (PC_next, ALU result and Read_Data_2 concatenated).
REQ-002 Parameter CTRL_W, default 8, SHALL set the width of the control payload (Branch, MemRead, MemToReg, MemWrite, RegWrite, Jump, Zero, spare).
REQ-003 Parameter SKID, default 1, SHALL select the buffer depth: 1 = 2-entry skid buffer; 0 = single register with combinational ready.
REQ-004 clk  in  1  the only clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  stage can accept an entry this cycle.
REQ-009 in_data  in  DATA_W  upstream datapath payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 out_valid  out  1  head entry present.
REQ-012 out_ready  in  1  downstream accepts the head entry.
REQ-013 out_data  out  DATA_W  head datapath payload.
REQ-014 out_ctrl  out  CTRL_W  head control payload; all zeros when out_valid=0.
REQ-015 occupancy  out  2  number of held entries (0..2).
REQ-016 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-017 An input handshake SHALL occur when in_valid and in_ready are both 1 on a rising edge; an output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-018 Latency in->out SHALL be exactly 1 cycle into an empty stage; throughput SHALL be 1 entry per cycle while out_ready=1.
REQ-019 With SKID=1, the block SHALL use states EMPTY (0 entries), ONE (main valid) and FULL (main and skid valid).
REQ-020 EMPTY: input handshake -> ONE, with main loaded.
REQ-021 ONE: input and output handshakes together -> ONE, with main reloaded; input only -> FULL, with skid loaded; output only -> EMPTY.
REQ-022 FULL: output handshake -> ONE, with skid moved to main; no input SHALL be accepted in FULL.
REQ-023 With SKID=1, in_ready SHALL equal NOT(state==FULL) and SHALL be driven from a register, with no combinational path from out_ready.
REQ-024 With SKID=0, in_ready SHALL equal (NOT out_valid) OR out_ready (combinational), and occupancy SHALL never exceed 1.
REQ-025 Entries SHALL leave in arrival order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-026 When flush=1, the stage SHALL go to EMPTY on the next edge, and any input handshake in that same cycle SHALL be discarded; in_ready SHALL NOT depend on flush.
REQ-027 flush and reset asserted together SHALL behave as reset.
REQ-028 out_data SHALL hold its last value while out_valid=0; out_ctrl SHALL be forced to zero so that a bubble never writes registers or memory.
REQ-029 stall_cnt SHALL increment on each cycle with out_valid=1 and out_ready=0, and SHALL saturate at 16'hFFFF.
REQ-030 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-031 On reset the block SHALL clear state to EMPTY, out_valid to 0, out_data and out_ctrl to 0, occupancy to 0 and stall_cnt to 0, and SHALL set in_ready to 1 (SKID=1) in the following cycle.
REQ-032 Reset asserted mid-operation SHALL discard all held entries, with no output handshake reported for them.

Structure
REQ-033 The shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, FULL), the control-bit index constants and the default DATA_W and CTRL_W values.
REQ-034 The block SHALL contain exactly one sub-module, pipe_entry_reg (a loadable DATA_W+CTRL_W register with valid bit), instantiated twice for main and skid when SKID=1.

Verification
REQ-035 Reset, then in_data=96'h1, in_ctrl=8'h10, 1 valid cycle, out_ready=1 -> out_valid=1 with data 96'h1 exactly 1 cycle later, then 0; occupancy returns to 0.
REQ-036 Stream 8 back-to-back entries 1..8 with out_ready=1 -> 8 consecutive outputs 1..8, no gaps, stall_cnt=0.
REQ-037 SKID=1, out_ready=0, in_valid held with values A, B, C -> A and B held, occupancy=2, in_ready=0, C not accepted; raise out_ready -> outputs A, B, C in order.
REQ-038 With occupancy=2, assert flush while in_valid=1 with D -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and D never appears at the output.
REQ-039 Hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and does not wrap.
REQ-040 SKID=0, out_ready toggling every cycle with in_valid=1 -> in_ready tracks (NOT out_valid) OR out_ready in the same cycle, and occupancy never exceeds 1.
